// File: rtl/bus_pkg.sv
// Shared main-bus definitions for the cache-side bus master: command encodings,
// line geometry and the master FSM state type.
package bus_pkg;

  localparam logic BUS_CMD_READ  = 1'b1;
  localparam logic BUS_CMD_WRITE = 1'b0;

  localparam int unsigned LINE_BYTES = 16;
  localparam int unsigned BEATS      = 4;

  typedef logic [BEATS*32-1:0] line_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RCMD,
    ST_RDATA,
    ST_WRITE,
    ST_DONE
  } cbm_state_t;

endpackage

// File: rtl/cache_bus_master.sv
// Cache-side main-bus initiator: one line refill/writeback per request as a command
// plus a BEATS-beat burst. Define CBM_TIMEOUT_EN to enable the transaction watchdog.
module cache_bus_master #(
  parameter int unsigned BEATS       = bus_pkg::BEATS,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                  clk_core,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [23:0]           req_addr,
  input  logic [BEATS*32-1:0]   req_wline,
  input  logic [BEATS*4-1:0]    req_wmask,
  output logic                  resp_valid,
  output logic                  resp_error,
  output logic [BEATS*32-1:0]   resp_rline,
  output logic                  cbm_cvalid,
  input  logic                  bus_cready,
  output logic                  cbm_cmd,
  output logic [25:0]           cbm_addr,
  output logic                  cbm_wvalid,
  input  logic                  bus_wready,
  output logic                  cbm_wlast,
  output logic [31:0]           cbm_wdata,
  output logic [3:0]            cbm_wmask,
  input  logic                  bus_rvalid,
  output logic                  cbm_rready,
  input  logic                  bus_rlast,
  input  logic [31:0]           bus_rdata,
  input  logic                  bus_error
);
  import bus_pkg::*;

  localparam int unsigned BW = $clog2(BEATS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  if ((BEATS < 2) || ((BEATS & (BEATS - 1)) != 0) || (TIMEOUT_CYC == 0)) begin : g_param_check
    $error("cache_bus_master: BEATS must be a power of two >= 2 and TIMEOUT_CYC nonzero");
  end

  cbm_state_t            state_q, state_d;
  logic [23:0]           addr_q, addr_d;
  logic [BEATS*32-1:0]   wline_q, wline_d;
  logic [BEATS*4-1:0]    wmask_q, wmask_d;
  logic [BEATS*32-1:0]   rline_q, rline_d;
  logic [BW-1:0]         beat_cnt_q, beat_cnt_d;
  logic                  cmd_done_q, cmd_done_d;
  logic                  data_done_q, data_done_d;
  logic                  err_q, err_d;

  logic req_hs, cmd_hs, wr_hs, rd_hs;

`ifdef CBM_TIMEOUT_EN
  localparam int unsigned WDW = $clog2(TIMEOUT_CYC + 1);
  logic [WDW-1:0] wdog_q, wdog_d;
`endif

  assign req_hs = req_valid & req_ready;
  assign cmd_hs = cbm_cvalid & bus_cready;
  assign wr_hs  = cbm_wvalid & bus_wready;
  assign rd_hs  = cbm_rready & bus_rvalid;

  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      addr_q      <= '0;
      wline_q     <= '0;
      wmask_q     <= '0;
      rline_q     <= '0;
      beat_cnt_q  <= '0;
      cmd_done_q  <= 1'b0;
      data_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      wline_q     <= wline_d;
      wmask_q     <= wmask_d;
      rline_q     <= rline_d;
      beat_cnt_q  <= beat_cnt_d;
      cmd_done_q  <= cmd_done_d;
      data_done_q <= data_done_d;
      err_q       <= err_d;
    end
  end

`ifdef CBM_TIMEOUT_EN
  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) wdog_q <= '0;
    else          wdog_q <= wdog_d;
  end
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wline_d     = wline_q;
    wmask_d     = wmask_q;
    rline_d     = rline_q;
    beat_cnt_d  = beat_cnt_q;
    cmd_done_d  = cmd_done_q;
    data_done_d = data_done_q;
    err_d       = err_q | ((state_q != ST_IDLE) & bus_error);

    unique case (state_q)
      ST_IDLE: begin
        if (req_hs) begin
          addr_d  = req_addr;
          wline_d = req_wline;
          wmask_d = req_wmask;
          state_d = req_write ? ST_WRITE : ST_RCMD;
        end
      end
      ST_RCMD: begin
        if (cmd_hs) state_d = ST_RDATA;
      end
      ST_RDATA: begin
        if (rd_hs) begin
          rline_d[{beat_cnt_q, 5'b0} +: 32] = bus_rdata;
          beat_cnt_d = beat_cnt_q + 1'b1;
          // rlast must coincide exactly with the final beat; either mismatch is an error
          if (bus_rlast != (beat_cnt_q == LAST_BEAT)) err_d = 1'b1;
          if (bus_rlast || (beat_cnt_q == LAST_BEAT)) state_d = ST_DONE;
        end
      end
      ST_WRITE: begin
        if (cmd_hs) cmd_done_d = 1'b1;
        if (wr_hs) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (beat_cnt_q == LAST_BEAT) data_done_d = 1'b1;
        end
        if (cmd_done_d && data_done_d) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d     = ST_IDLE;
        beat_cnt_d  = '0;
        cmd_done_d  = 1'b0;
        data_done_d = 1'b0;
        err_d       = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef CBM_TIMEOUT_EN
    wdog_d = '0;
    if (state_q inside {ST_RCMD, ST_RDATA, ST_WRITE}) begin
      if (cmd_hs || wr_hs || rd_hs) begin
        wdog_d = '0;
      end else if (wdog_q == WDW'(TIMEOUT_CYC - 1)) begin
        state_d = ST_DONE;
        err_d   = 1'b1;
      end else begin
        wdog_d = wdog_q + 1'b1;
      end
    end
`endif
  end

  always_comb begin
    req_ready  = (state_q == ST_IDLE);
    cbm_cvalid = (state_q == ST_RCMD) | ((state_q == ST_WRITE) & ~cmd_done_q);
    cbm_cmd    = (state_q == ST_RCMD) ? BUS_CMD_READ : BUS_CMD_WRITE;
    cbm_addr   = '0;
    if ((state_q == ST_RCMD) || ((state_q == ST_WRITE) && !cmd_done_q)) cbm_addr = {addr_q, 2'b00};
    cbm_wvalid = (state_q == ST_WRITE) & ~data_done_q;
    cbm_wlast  = '0;
    cbm_wdata  = '0;
    cbm_wmask  = '0;
    if ((state_q == ST_WRITE) && !data_done_q) begin
      cbm_wlast = (beat_cnt_q == LAST_BEAT);
      cbm_wdata = wline_q[{beat_cnt_q, 5'b0} +: 32];
      cbm_wmask = wmask_q[{beat_cnt_q, 2'b0} +: 4];
    end
    cbm_rready = (state_q == ST_RDATA);
    resp_valid = (state_q == ST_DONE);
    resp_error = (state_q == ST_DONE) & err_q;
  end

  assign resp_rline = rline_q;

endmodule
